peach_lsu: RTL and testbench

PEACH_LSU -- requirements
Module: peach_lsu

---
 rtl/peach_lsu_if.sv | 35 +++
 rtl/peach_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_peach_lsu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/peach_lsu_if.sv
// Bundle of core-request, response and memory-side signals for the PEACH load/store unit.
// The slave modport is the LSU's view; master is the core/memory environment.
interface peach_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/peach_lsu.sv
// Single-outstanding RV32I load/store unit: decodes, aligns and sign-extends
// accesses to a word-addressed memory port, with an optional wait-state timeout.
module peach_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic         clk,
    input logic         reset,
    peach_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    function automatic logic req_legal(input logic store, input logic [2:0] f3);
        logic ok;
        if (store) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
        end
        return ok;
    endfunction

    function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            2'b10:   d = w;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Lane select by the low address bits, then sign/zero extension by funct3.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (lo)
            2'b00:   b = r[7:0];
            2'b01:   b = r[15:8];
            2'b10:   b = r[23:16];
            2'b11:   b = r[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? r[31:16] : r[15:0];
        case (f3)
            3'b000:  d = {{24{b[7]}}, b};
            3'b001:  d = {{16{h[15]}}, h};
            3'b010:  d = r;
            3'b100:  d = {24'h00_0000, b};
            3'b101:  d = {16'h0000, h};
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Next-state, memory-port and response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d   = bus.req_store;
                    funct3_d  = bus.req_funct3;
                    addr_lo_d = bus.req_addr[1:0];
                    cnt_d     = 8'd0;
                    if (req_legal(bus.req_store, bus.req_funct3) &&
                        !req_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d     = S_ACCESS;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_d = bus.req_store ? store_strobe(bus.req_funct3, bus.req_addr[1:0])
                                                    : 4'b0000;
                        mem_wdata_d = bus.req_store ? store_data(bus.req_funct3, bus.req_wdata)
                                                    : 32'h0000_0000;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                // A ready in the final wait cycle beats the timeout.
                if (bus.mem_ready) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = store_q ? 32'h0000_0000
                                          : load_extract(funct3_q, addr_lo_q, bus.mem_rdata);
                    mem_valid_d = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0000_0000;
                end else if ((TIMEOUT_LIMIT != 9'd0) && (({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIMIT)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
                mem_addr_d  = 32'h0000_0000;
                mem_wstrb_d = 4'b0000;
                mem_wdata_d = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers; reset drops the memory request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_peach_lsu.sv
// Directed self-checking bench for peach_lsu (TIMEOUT_CYCLES=4) with hand-computed expectations.
module tb_peach_lsu;

    logic clk;
    logic reset;
    int   checks_cnt;
    int   fail_cnt;
    int   valid_cycles;
    logic saw_rsp;

    peach_lsu_if bus ();

    peach_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accept edge, then withdraws it.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = w;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        checks_cnt     = 0;
        fail_cnt       = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        tick();
        tick();
        check_eq("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_mem_addr",  bus.mem_addr, 32'h0);
        reset = 1'b0;
        tick();
        check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // LB 0x13 with ready already high.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h80FF_1234;
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        check_eq("lb_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
        check_eq("lb_mem_addr",  bus.mem_addr, 32'h0000_0010);
        check_eq("lb_wstrb",     {28'd0, bus.mem_wstrb}, 32'h0);
        check_eq("lb_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check_eq("lb_rsp_early", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check_eq("lb_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("lb_rsp_rdata", bus.rsp_rdata, 32'hFFFF_FF80);
        check_eq("lb_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        check_eq("lb_mem_drop",  {31'd0, bus.mem_valid}, 32'd0);
        // A request during RESP must wait for IDLE.
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0040;
        bus.mem_ready  = 1'b0;
        tick();
        check_eq("resp_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("resp_no_accept", {31'd0, bus.mem_valid}, 32'd0);
        check_eq("idle_ready",     {31'd0, bus.req_ready}, 32'd1);
        check_eq("rdata_hold",     bus.rsp_rdata, 32'hFFFF_FF80);
        tick();
        bus.req_valid = 1'b0;
        check_eq("late_accept", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        check_eq("lw_rdata", bus.rsp_rdata, 32'h1234_5678);
        bus.mem_ready = 1'b0;
        tick();

        // SH 0x102 lands in the upper half.
        issue(1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF);
        check_eq("sh_mem_addr", bus.mem_addr, 32'h0000_0100);
        check_eq("sh_wstrb",    {28'd0, bus.mem_wstrb}, 32'hC);
        check_eq("sh_wdata",    bus.mem_wdata, 32'hBEEF_BEEF);
        bus.mem_ready = 1'b1;
        tick();
        check_eq("sh_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("sh_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        check_eq("sh_rsp_rdata", bus.rsp_rdata, 32'h0);
        bus.mem_ready = 1'b0;
        tick();

        // SB 0x201 replicates one byte.
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5);
        check_eq("sb_wstrb", {28'd0, bus.mem_wstrb}, 32'h2);
        check_eq("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();

        // Misaligned LW: straight to error response.
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        check_eq("mis_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check_eq("mis_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("mis_rsp_error", {31'd0, bus.rsp_error}, 32'd1);
        check_eq("mis_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick();
        check_eq("mis_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);

        // Illegal store funct3.
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        check_eq("ill_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check_eq("ill_rsp_error", {31'd0, bus.rsp_error}, 32'd1);
        tick();

        // Timeout with ready held low.
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        valid_cycles = 0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!saw_rsp) begin
                if (bus.mem_valid) valid_cycles++;
                if (bus.rsp_valid) saw_rsp = 1'b1;
                else tick();
            end
        end
        check_eq("to_rsp_seen",    {31'd0, saw_rsp}, 32'd1);
        check_eq("to_valid_count", valid_cycles, 32'd4);
        check_eq("to_rsp_error",   {31'd0, bus.rsp_error}, 32'd1);
        check_eq("to_rsp_rdata",   bus.rsp_rdata, 32'h0);
        tick();

        // Ready on the 4th wait cycle beats the timeout.
        bus.mem_rdata = 32'h1122_3344;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        tick();
        tick();
        tick();
        check_eq("edge_still_valid", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        check_eq("edge_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("edge_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        check_eq("edge_rsp_rdata", bus.rsp_rdata, 32'h1122_3344);
        bus.mem_ready = 1'b0;
        tick();

        // LHU 0x2 after three wait cycles; memory port stays stable.
        bus.mem_rdata = 32'h8001_0000;
        issue(1'b0, 3'b101, 32'h0000_0002, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            check_eq("lhu_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
            check_eq("lhu_mem_addr",  bus.mem_addr, 32'h0);
            check_eq("lhu_wstrb",     {28'd0, bus.mem_wstrb}, 32'h0);
            check_eq("lhu_wdata",     bus.mem_wdata, 32'h0);
            tick();
        end
        check_eq("lhu_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("lhu_rsp_rdata", bus.rsp_rdata, 32'h0000_8001);
        bus.mem_ready = 1'b0;
        tick();

        // Reset in the middle of an access.
        issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
        check_eq("rstmid_pre_valid", {31'd0, bus.mem_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rstmid_drop", {31'd0, bus.mem_valid}, 32'd0);
        bus.mem_ready = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check_eq("rstmid_no_rsp",    {31'd0, saw_rsp}, 32'd0);
        check_eq("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("rstmid_rdata",     bus.rsp_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
